prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter NUM_PROGS, default 3: number of programs run back-to-back per batch (range 1..8).
REQ-002 SHALL have parameter START_CYCLES, default 2: number of cycles Start is held high per program (minimum 1).
REQ-003 SHALL have parameter TIMEOUT, default 16'hFFFF: number of RUN cycles after which a program is abandoned.
REQ-004 SHALL have port Clk, input, 1 bit: single clock, posedge used.
REQ-005 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Go, input, 1 bit: request to run a batch, level-sensitive.
REQ-007 SHALL have port Start, output, 1 bit: drives the processor Start input.
REQ-008 SHALL have port Ack, input, 1 bit: processor done flag.
REQ-009 SHALL have port Busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-010 SHALL have port Done, output, 1 bit: high in DONE.
REQ-011 SHALL have port ProgIdx, output, 3 bits: index of the current or last program.
REQ-012 SHALL have port ResultSel, input, 3 bits: selects the result slot for readback.
REQ-013 SHALL have port ResultCycles, output, 16 bits: cycle count of slot ResultSel, combinational read.
REQ-014 SHALL have port TimeoutMask, output, NUM_PROGS bits: bit i set when program i timed out.

Function
REQ-015 SHALL implement the states IDLE, START, RUN, GAP and DONE.
REQ-016 In IDLE with Go=1 at a posedge, SHALL clear ProgIdx, all result slots and TimeoutMask, and enter START.
REQ-017 In START, SHALL drive Start=1 for exactly START_CYCLES cycles, then enter RUN with the run counter at 0.
REQ-018 In RUN, SHALL drive Start=0 and increment the run counter by 1 every cycle, saturating at 16'hFFFF.
REQ-019 In RUN with Ack=1, SHALL write the counter value including the current cycle (first RUN cycle counts as 1) into slot ProgIdx.
REQ-020 In RUN with counter+1 == TIMEOUT and Ack=0, SHALL write TIMEOUT into slot ProgIdx and set TimeoutMask[ProgIdx].
REQ-021 If Ack=1 and the timeout condition occur in the same cycle, SHALL treat the cycle as an Ack and leave the mask bit clear.
REQ-022 After RUN ends, SHALL enter DONE if ProgIdx == NUM_PROGS-1, otherwise GAP.
REQ-023 GAP SHALL last 1 cycle with Start=0, increment ProgIdx, then enter START.
REQ-024 SHALL ignore Ack in IDLE, START, GAP and DONE.
REQ-025 SHALL ignore Go while Busy.
REQ-026 DONE SHALL hold, keeping results and ProgIdx, until Go=0 is sampled, then enter IDLE.
REQ-027 For ResultSel >= NUM_PROGS, ResultCycles SHALL read 0.
REQ-028 Start SHALL be a registered output with no combinational path from Go or Ack.

Reset
REQ-029 Reset=1 SHALL immediately, independent of Clk, force IDLE, Start=0, Busy=0, Done=0, ProgIdx=0, TimeoutMask=0, all slots and the counter 0.
REQ-030 Reset asserted mid-batch SHALL abandon the batch; after release, a new batch SHALL need Go=1 from IDLE.

Structure
REQ-031 The state enum and the default values of NUM_PROGS, START_CYCLES and TIMEOUT SHALL live in shared package prog_seq_pkg.
REQ-032 The saturating 16-bit run counter SHALL be the single sub-module sat_counter, with ports Clk, Reset, Clear, En and Count.
REQ-033 Result slots SHALL be a register array of NUM_PROGS x 16 bits.

Verification (NUM_PROGS=3, START_CYCLES=2, TIMEOUT=20)
REQ-034 Go=1; Ack on the 5th, 7th and 9th RUN cycle of programs 0/1/2 -> slots read 5/7/9, TimeoutMask=000, Done=1, Start high for exactly 2 cycles per program, 1 GAP cycle between programs.
REQ-035 Program 1 never acks -> slot1=20, TimeoutMask=010, program 2 still runs and completes.
REQ-036 Ack held high throughout START -> ignored; slot written only on the first RUN cycle, value 1.
REQ-037 Reset pulsed during RUN of program 1 -> outputs 0 and Start=0 immediately; Go low then high afterwards restarts from program 0.
REQ-038 Ack=1 on RUN cycle 20 -> slot=20, mask bit clear; ResultSel=5 -> ResultCycles=0.
REQ-039 Go held high through DONE -> stays in DONE and no second batch; Go=0 then 1 -> new batch with results cleared.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the program sequencer.
package prog_seq_pkg;

  localparam int unsigned DEF_NUM_PROGS    = 3;
  localparam int unsigned DEF_START_CYCLES = 2;
  localparam logic [15:0] DEF_TIMEOUT      = 16'hFFFF;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating 16-bit cycle counter with synchronous clear and enable.
module sat_counter
  import prog_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  output logic [CNT_W-1:0] Count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable; enable counts up and sticks at the top.
  always_comb begin
    count_d = count_q;
    if (Clear) begin
      count_d = '0;
    end else if (En) begin
      count_d = sat_inc(count_q);
    end
  end

  // Count register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Runs NUM_PROGS programs back-to-back on a processor via a Start/Ack
// handshake, recording each program's run length or a timeout.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned NUM_PROGS    = DEF_NUM_PROGS,
  parameter int unsigned START_CYCLES = DEF_START_CYCLES,
  parameter logic [15:0] TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Go,
  output logic                 Start,
  input  logic                 Ack,
  output logic                 Busy,
  output logic                 Done,
  output logic [IDX_W-1:0]     ProgIdx,
  input  logic [IDX_W-1:0]     ResultSel,
  output logic [CNT_W-1:0]     ResultCycles,
  output logic [NUM_PROGS-1:0] TimeoutMask
);

  localparam int unsigned    SC_W     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(START_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PROGS - 1);

  state_e state_q;
  state_e state_d;

  logic [SC_W-1:0]      scnt_q;
  logic [SC_W-1:0]      scnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [CNT_W-1:0]     slots_q [NUM_PROGS];
  logic [CNT_W-1:0]     slots_d [NUM_PROGS];
  logic [NUM_PROGS-1:0] mask_q;
  logic [NUM_PROGS-1:0] mask_d;
  logic                 start_q;
  logic                 start_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;

  logic                 cnt_clear;
  logic                 cnt_en;
  logic [CNT_W-1:0]     run_cnt;
  logic [CNT_W-1:0]     run_val;
  logic                 ack_hit;
  logic                 to_hit;
  logic                 run_end;
  logic [CNT_W-1:0]     rd_data;

  // Run-length counter: held at zero outside RUN, counts every RUN cycle.
  sat_counter u_run_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (cnt_clear),
    .En    (cnt_en),
    .Count (run_cnt)
  );

  // Length including the current RUN cycle; Ack takes priority over timeout.
  assign run_val = sat_inc(run_cnt);
  assign ack_hit = (state_q == ST_RUN) && Ack;
  assign to_hit  = (state_q == ST_RUN) && !Ack && (run_val == TIMEOUT);
  assign run_end = ack_hit || to_hit;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Go) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (scnt_q == SC_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_end) begin
          state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_START;
      end
      ST_DONE: begin
        if (!Go) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output and datapath next values; flags are registered from state_d.
  always_comb begin
    scnt_d    = '0;
    idx_d     = idx_q;
    slots_d   = slots_q;
    mask_d    = mask_q;
    cnt_clear = (state_q != ST_RUN);
    cnt_en    = (state_q == ST_RUN);

    unique case (state_q)
      ST_IDLE: begin
        if (Go) begin
          idx_d  = '0;
          mask_d = '0;
          for (int i = 0; i < NUM_PROGS; i++) begin
            slots_d[i] = '0;
          end
        end
      end
      ST_START: begin
        if (scnt_q != SC_LAST) begin
          scnt_d = scnt_q + SC_W'(1);
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_PROGS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            if (ack_hit) begin
              slots_d[i] = run_val;
            end else if (to_hit) begin
              slots_d[i] = TIMEOUT;
              mask_d[i]  = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        idx_d = idx_q + IDX_W'(1);
      end
      default: begin
      end
    endcase

    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_GAP);
    done_d  = (state_d == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scnt_q  <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_PROGS; i++) begin
        slots_q[i] <= slots_d[i];
      end
    end
  end

  // Result readback; unpopulated slot indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (ResultSel == IDX_W'(i)) begin
        rd_data = slots_q[i];
      end
    end
  end

  assign Start        = start_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign ProgIdx      = idx_q;
  assign ResultCycles = rd_data;
  assign TimeoutMask  = mask_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomised directed bench for prog_sequencer against a cycle-level model.
module tb_prog_sequencer;

  localparam int unsigned NP = 3;
  localparam int unsigned SC = 2;
  localparam int          TO = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Go;
  logic          Start;
  logic          Ack;
  logic          Busy;
  logic          Done;
  logic [2:0]    ProgIdx;
  logic [2:0]    ResultSel;
  logic [15:0]   ResultCycles;
  logic [NP-1:0] TimeoutMask;

  int n_pass  = 0;
  int n_total = 0;

  prog_sequencer #(
    .NUM_PROGS    (NP),
    .START_CYCLES (SC),
    .TIMEOUT      (16'(TO))
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Go           (Go),
    .Start        (Start),
    .Ack          (Ack),
    .Busy         (Busy),
    .Done         (Done),
    .ProgIdx      (ProgIdx),
    .ResultSel    (ResultSel),
    .ResultCycles (ResultCycles),
    .TimeoutMask  (TimeoutMask)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_ctl(input string tag, input bit e_start, input bit e_busy,
                           input bit e_done, input int e_idx);
    check({tag, ".Start"},   32'(Start),   32'(e_start));
    check({tag, ".Busy"},    32'(Busy),    32'(e_busy));
    check({tag, ".Done"},    32'(Done),    32'(e_done));
    check({tag, ".ProgIdx"}, 32'(ProgIdx), 32'(e_idx));
  endtask

  task automatic check_results(input string tag, input int e0, input int e1, input int e2,
                               input logic [NP-1:0] e_mask);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int i = 0; i < 3; i++) begin
      ResultSel = 3'(i);
      #1;
      check($sformatf("%s.slot%0d", tag, i), 32'(ResultCycles), 32'(e[i]));
    end
    ResultSel = 3'd5;
    #1;
    check({tag, ".slot5"}, 32'(ResultCycles), 32'd0);
    ResultSel = 3'd7;
    #1;
    check({tag, ".slot7"}, 32'(ResultCycles), 32'd0);
    check({tag, ".mask"}, 32'(TimeoutMask), 32'(e_mask));
  endtask

  // A program ends on its first Ack within the timeout window, else at TO.
  function automatic bit acked(input int a);
    return (a >= 1) && (a <= TO);
  endfunction

  function automatic int exp_slot(input int a);
    return acked(a) ? a : TO;
  endfunction

  // Asynchronous reset between clock edges, then two idle cycles with Go low.
  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    check_ctl({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 0);
    check_results({tag, ".rst"}, 0, 0, 0, '0);
    Go  = 1'b0;
    Ack = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check_ctl({tag, ".post_rst"}, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_ctl({tag, ".post_rst2"}, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // One batch from IDLE. ack_at[p]=k raises Ack on RUN cycle k of program p
  // (0 = never). abort_p >= 0 resets during program abort_p: in RUN cycle
  // abort_k, or in its first START cycle when abort_k is 0.
  task automatic run_batch(input string tag, input int a0, input int a1, input int a2,
                           input bit ack_start_hi, input int abort_p, input int abort_k);
    int ack_at[3];
    logic [NP-1:0] em;
    ack_at[0] = a0; ack_at[1] = a1; ack_at[2] = a2;
    Ack = 1'($urandom_range(0, 1));
    Go  = 1'b1;
    tick();
    check_results({tag, ".cleared"}, 0, 0, 0, '0);
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < SC; s++) begin
        check_ctl($sformatf("%s.p%0d.start%0d", tag, p, s), 1'b1, 1'b1, 1'b0, p);
        if (p == abort_p && abort_k == 0 && s == 0) begin
          do_reset(tag);
          return;
        end
        Ack = ack_start_hi ? 1'b1 : 1'($urandom_range(0, 1));
        Go  = 1'($urandom_range(0, 1));
        tick();
      end
      for (int k = 1; k <= TO; k++) begin
        check_ctl($sformatf("%s.p%0d.run%0d", tag, p, k), 1'b0, 1'b1, 1'b0, p);
        if (p == abort_p && k == abort_k) begin
          do_reset(tag);
          return;
        end
        Ack = (k == ack_at[p]);
        Go  = 1'($urandom_range(0, 1));
        tick();
        if (k == ack_at[p]) break;
      end
      if (p < 2) begin
        check_ctl($sformatf("%s.p%0d.gap", tag, p), 1'b0, 1'b1, 1'b0, p);
        Ack = 1'($urandom_range(0, 1));
        Go  = 1'($urandom_range(0, 1));
        tick();
      end
    end
    Ack = 1'b0;
    check_ctl({tag, ".done"}, 1'b0, 1'b0, 1'b1, 2);
    em = '0;
    for (int p = 0; p < 3; p++) begin
      if (!acked(ack_at[p])) em[p] = 1'b1;
    end
    check_results({tag, ".res"}, exp_slot(a0), exp_slot(a1), exp_slot(a2), em);
  endtask

  // Leave DONE by dropping Go; index and results stay put in IDLE.
  task automatic to_idle(input string tag);
    Go  = 1'b0;
    Ack = 1'($urandom_range(0, 1));
    tick();
    check_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 2);
  endtask

  initial begin
    Reset     = 1'b1;
    Go        = 1'b0;
    Ack       = 1'b0;
    ResultSel = 3'd0;
    #2;
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 0);
    check_results("reset", 0, 0, 0, '0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    Go    = 1'b0;
    tick();
    check_ctl("idle0", 1'b0, 1'b0, 1'b0, 0);

    // Acks on RUN cycles 5, 7, 9.
    run_batch("b_basic", 5, 7, 9, 1'b0, -1, 0);
    to_idle("b_basic");

    // Program 1 never acks and times out.
    run_batch("b_tmo", 4, 0, 6, 1'b0, -1, 0);
    to_idle("b_tmo");

    // Ack held through START is ignored; first RUN cycle records 1.
    run_batch("b_early", 1, 1, 1, 1'b1, -1, 0);
    to_idle("b_early");

    // Ack exactly on the timeout cycle, and an Ack one cycle too late.
    run_batch("b_edge", 20, 3, 21, 1'b0, -1, 0);

    // Go held through DONE keeps DONE and does not restart.
    Go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Ack = 1'($urandom_range(0, 1));
      tick();
      check_ctl($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 2);
    end
    check_results("hold", 20, 3, 20, 3'b100);
    to_idle("hold");

    // Reset in RUN of program 1, then a fresh batch from program 0.
    run_batch("b_rst_run", 3, 10, 5, 1'b0, 1, 4);
    run_batch("b_after_rst", 2, 8, 0, 1'b0, -1, 0);
    to_idle("b_after_rst");

    // Reset in START of program 2.
    run_batch("b_rst_start", 6, 6, 6, 1'b0, 2, 0);

    // Random batches.
    for (int r = 0; r < 8; r++) begin
      run_batch($sformatf("rand%0d", r), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 24)), int'($urandom_range(0, 24)),
                1'($urandom_range(0, 1)), -1, 0);
      if ($urandom_range(0, 1) == 1) begin
        Go = 1'b1;
        tick();
        check_ctl($sformatf("rand%0d.hold", r), 1'b0, 1'b0, 1'b1, 2);
      end
      to_idle($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
